// File: rtl/cordic_atan2.sv
// Iterative vectoring-mode CORDIC: atan2(y, x) in degrees x 2^30 and vector magnitude.
// Define CORDIC_GAIN_COMP_EN to add a GAIN cycle that scales the magnitude by 1/K.
module cordic_atan2 #(
  parameter int XY_W  = 16,
  parameter int ITERS = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XY_W-1:0] x_in,
  input  logic [XY_W-1:0] y_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [39:0]     angle_out,
  output logic [XY_W+3:0] mag_out
);

  localparam int W = XY_W + 4;
  localparam logic signed [39:0] DEG90 = 40'sh1680000000;

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ITER, GAIN, OUT} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, OUT} state_t;
`endif

  state_t              state_q, state_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d;
  logic signed [39:0]  z_q, z_d;
  logic [4:0]          iter_q, iter_d;

  logic signed [W-1:0] x_ext, y_ext, x_sh, y_sh;
  logic signed [39:0]  theta;

  assign x_ext = {{4{x_in[XY_W-1]}}, x_in};
  assign y_ext = {{4{y_in[XY_W-1]}}, y_in};
  assign x_sh  = x_q >>> iter_q;
  assign y_sh  = y_q >>> iter_q;

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [15:0] INV_K = 16'sh4DBA;
  logic signed [W+15:0] prod;
  assign prod = x_q * INV_K;
`endif

  // atan(2^-i) in degrees x 2^30
  always_comb begin
    theta = '0;
    case (iter_q)
      5'd0:  theta = 40'sh0B40000000;
      5'd1:  theta = 40'sh06A429CC6C;
      5'd2:  theta = 40'sh038251D01F;
      5'd3:  theta = 40'sh01C8004492;
      5'd4:  theta = 40'sh00E4E2A993;
      5'd5:  theta = 40'sh00728DE539;
      5'd6:  theta = 40'sh00394A86AC;
      5'd7:  theta = 40'sh001CA5B5E8;
      5'd8:  theta = 40'sh000E52E946;
      5'd9:  theta = 40'sh000729766E;
      5'd10: theta = 40'sh000394BB70;
      5'd11: theta = 40'sh0001CA5DBF;
      5'd12: theta = 40'sh0000E52EE0;
      5'd13: theta = 40'sh0000729770;
      5'd14: theta = 40'sh0000394BB8;
      5'd15: theta = 40'sh00001CA5DC;
      5'd16: theta = 40'sh00000E52EE;
      5'd17: theta = 40'sh0000072976;
      default: theta = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          iter_d  = '0;
          state_d = ITER;
          // Fold the vector into the right half-plane; +-90 deg pre-loads z.
          if (!x_ext[W-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!y_ext[W-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = DEG90;
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -DEG90;
          end
        end
      end
      ITER: begin
        if (!y_q[W-1]) begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + theta;
        end else begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - theta;
        end
        // A zero vector never rotates, so its angle stays at zero.
        if (x_q == '0 && y_q == '0) begin
          z_d = '0;
        end
        iter_d = iter_q + 5'd1;
        if (iter_q == 5'(ITERS - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_d = GAIN;
`else
          state_d = OUT;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      GAIN: begin
        x_d     = prod[W+14:15];
        state_d = OUT;
      end
`endif
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == OUT);
  assign angle_out = out_valid ? z_q : '0;
  assign mag_out   = out_valid ? x_q : '0;

endmodule

// File: tb/tb_cordic_atan2.sv
// Scoreboard bench for cordic_atan2: expected angle/magnitude from a real-valued model.
module tb_cordic_atan2;

  localparam int XY_W  = 16;
  localparam int ITERS = 18;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int EXP_LAT = ITERS + 1;
  localparam bit GAIN_EN = 1'b1;
`else
  localparam int EXP_LAT = ITERS;
  localparam bit GAIN_EN = 1'b0;
`endif
  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = 1073741824.0;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x_in;
  logic [15:0] y_in;
  logic        out_valid;
  logic        out_ready;
  logic [39:0] angle_out;
  logic [19:0] mag_out;

  int checks = 0;
  int errors = 0;
  real k_gain;

  typedef struct {
    int  x;
    int  y;
    real ang;
    real ang_tol;
    real mag;
    real mag_tol;
    bit  exact;
  } exp_t;

  exp_t sb[$];

  cordic_atan2 #(.XY_W(XY_W), .ITERS(ITERS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_in(x_in), .y_in(y_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .angle_out(angle_out), .mag_out(mag_out)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int xv, input int yv);
    exp_t e;
    real  m;
    e.x = xv;
    e.y = yv;
    m = $sqrt(real'(xv) * real'(xv) + real'(yv) * real'(yv));
    e.exact = (xv == 0 && yv == 0);
    if (e.exact) begin
      e.ang = 0.0;
      e.ang_tol = 0.0;
    end else begin
      e.ang = $atan2(real'(yv), real'(xv)) * 180.0 / PI * SCALE;
      // Truncating shifts at input resolution leave a residual of a few input LSBs.
      e.ang_tol = 1114112.0 + 6.0 / (m * k_gain) * 180.0 / PI * SCALE;
    end
    e.mag = m * k_gain * (GAIN_EN ? 19898.0 / 32768.0 : 1.0);
    e.mag_tol = GAIN_EN ? 10.0 : 16.0;
    return e;
  endfunction

  task automatic send(input int xv, input int yv);
    int n = 0;
    x_in = 16'(xv);
    y_in = 16'(yv);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready in_ready=%0b required 1", in_ready);
    end
    @(posedge clk);
    sb.push_back(model(xv, yv));
    #1 in_valid = 1'b0;
  endtask

  task automatic collect(output int lat);
    exp_t   e;
    longint a;
    real    d;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_timeout out_valid=%0b required 1 within 100 cycles", out_valid);
      if (sb.size() > 0) e = sb.pop_front();
      return;
    end
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_output angle=0x%010h with empty scoreboard", angle_out);
    end else begin
      e = sb.pop_front();
      a = longint'($signed(angle_out));
      $display("txn x=%0d y=%0d angle=0x%010h mag=0x%05h latency=%0d",
               e.x, e.y, angle_out, mag_out, lat);
      checks++;
      if (e.exact) begin
        if (angle_out !== 40'd0) begin
          errors++;
          $display("FAIL angle_zero angle=0x%010h required 0", angle_out);
        end
      end else begin
        d = real'(a) - e.ang;
        if ((d < 0.0 ? -d : d) > e.ang_tol) begin
          errors++;
          $display("FAIL angle x=%0d y=%0d angle=%0d required %0.0f +- %0.0f",
                   e.x, e.y, a, e.ang, e.ang_tol);
        end
      end
      checks++;
      if (e.exact) begin
        if (mag_out !== 20'd0) begin
          errors++;
          $display("FAIL mag_zero mag=%0d required 0", mag_out);
        end
      end else begin
        d = real'(mag_out) - e.mag;
        if ((d < 0.0 ? -d : d) > e.mag_tol) begin
          errors++;
          $display("FAIL mag x=%0d y=%0d mag=%0d required %0.1f +- %0.0f",
                   e.x, e.y, mag_out, e.mag, e.mag_tol);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handshake out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x_in = '0;
    y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || angle_out !== 40'd0 || mag_out !== 20'd0) begin
      errors++;
      $display("FAIL reset_outputs out_valid=%0b angle=0x%010h mag=0x%05h required 0/0/0",
               out_valid, angle_out, mag_out);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_vectors();
    int lat;
    int xs[7] = '{16384, 16384,      0, -16384, 0, -32768, 30000};
    int ys[7] = '{    0, 16384, -16384,      0, 0, -32768, -32768};
    for (int i = 0; i < 7; i++) begin
      send(xs[i], ys[i]);
      collect(lat);
      checks++;
      if (lat != EXP_LAT) begin
        errors++;
        $display("FAIL latency x=%0d y=%0d latency=%0d required %0d", xs[i], ys[i], lat, EXP_LAT);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat = 0;
    logic [39:0] a0;
    logic [19:0] m0;
    send(12000, -7000);
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    a0 = angle_out;
    m0 = mag_out;
    for (int c = 0; c < 5; c++) begin
      x_in = 16'd100;
      y_in = 16'd200;
      in_valid = (c % 2 == 0);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || angle_out !== a0 || mag_out !== m0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold cycle=%0d out_valid=%0b in_ready=%0b angle=0x%010h mag=0x%05h required 1/0/0x%010h/0x%05h",
                 c, out_valid, in_ready, angle_out, mag_out, a0, m0);
      end
    end
    in_valid = 1'b0;
    collect(lat);
    repeat (EXP_LAT + 3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ignored_pulses out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_midreset();
    int lat;
    send(16384, 16384);
    repeat (7) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || angle_out !== 40'd0 || mag_out !== 20'd0) begin
      errors++;
      $display("FAIL midreset_outputs out_valid=%0b angle=0x%010h mag=0x%05h required 0/0/0",
               out_valid, angle_out, mag_out);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready in_ready=%0b required 1", in_ready);
    end
    repeat (EXP_LAT + 2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort out_valid=%0b required 0", out_valid);
    end
    send(16384, 16384);
    collect(lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    int xv;
    int yv;
    for (int i = 0; i < 6; i++) begin
      do begin
        xv = int'($urandom_range(65535)) - 32768;
        yv = int'($urandom_range(65535)) - 32768;
      end while (((xv < 0) ? -xv : xv) + ((yv < 0) ? -yv : yv) < 16384);
      send(xv, yv);
      collect(lat);
    end
  endtask

  initial begin
    real p;
    k_gain = 1.0;
    p = 1.0;
    for (int i = 0; i < ITERS; i++) begin
      k_gain = k_gain * $sqrt(1.0 + p);
      p = p / 4.0;
    end
    test_reset();
    test_vectors();
    test_backpressure();
    test_midreset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
